// File: rtl/compute_unit_0.sv
// compute_unit_0: 8-bit, 16-entry register-file compute unit.
// Executes one instruction per enabled clock. The opcode and destination
// arrive on ui_in, and the immediate or operand indices arrive on uio_in.
// The bidirectional pins are used as inputs only.
module compute_unit_0 #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst_n,   // active-high synchronous reset despite the name
    input  logic              ena,
    input  logic [7:0]        ui_in,
    input  logic [DATA_W-1:0] uio_in,
    output logic [DATA_W-1:0] uo_out,
    output logic [DATA_W-1:0] uio_out,
    output logic [DATA_W-1:0] uio_oe
);

    localparam logic [3:0] OP_READ = 4'b1000;
    localparam logic [3:0] OP_LOAD = 4'b1001;
    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b1011;
    localparam logic [3:0] OP_AND  = 4'b1100;
    localparam logic [3:0] OP_OR   = 4'b1101;
    localparam logic [3:0] OP_XOR  = 4'b1110;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [3:0]        opcode;
    logic [3:0]        idx_d;
    logic [3:0]        idx_a;
    logic [3:0]        idx_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result;
    logic              wr_en;
    logic              out_en;

    assign opcode = ui_in[7:4];
    assign idx_d  = ui_in[3:0];
    assign idx_a  = uio_in[7:4];
    assign idx_b  = uio_in[3:0];
    assign op_a   = regs[idx_a];
    assign op_b   = regs[idx_b];

    assign uio_out = '0;
    assign uio_oe  = '0;

    // Decode the opcode into a result value and its write and output enables.
    always_comb begin
        result = '0;
        wr_en  = 1'b0;
        out_en = 1'b0;
        case (opcode)
            OP_READ: begin
                result = regs[idx_d];
                out_en = 1'b1;
            end
            OP_LOAD: begin
                result = uio_in;
                wr_en  = 1'b1;
                out_en = 1'b1;
            end
            OP_ADD: begin
                result = op_a + op_b;
                wr_en  = 1'b1;
                out_en = 1'b1;
            end
            OP_SUB: begin
                result = op_a - op_b;
                wr_en  = 1'b1;
                out_en = 1'b1;
            end
            OP_AND: begin
                result = op_a & op_b;
                wr_en  = 1'b1;
                out_en = 1'b1;
            end
            OP_OR: begin
                result = op_a | op_b;
                wr_en  = 1'b1;
                out_en = 1'b1;
            end
            OP_XOR: begin
                result = op_a ^ op_b;
                wr_en  = 1'b1;
                out_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Register-file and output update. Operands come from pre-edge values,
    // so a destination that is also a source sees its old contents.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            uo_out <= '0;
        end else if (ena) begin
            if (wr_en) begin
                regs[idx_d] <= result;
            end
            if (out_en) begin
                uo_out <= result;
            end
        end
    end

endmodule

// File: tb/tb_compute_unit_0.sv
// Self-checking bench for compute_unit_0. It uses directed scenarios with
// literal expected values and a randomized run that is checked against a
// behavioural model of the instruction set.
module tb_compute_unit_0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fails  = 0;

    int m_regs [16];
    int m_out;

    compute_unit_0 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, let the edge happen, and advance the model.
    task automatic apply(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] uio);
        int op, d, va, vb, res;
        bit wr, upd;
        rst_n  = r;
        ena    = e;
        ui_in  = ui;
        uio_in = uio;
        @(posedge clk);
        op = int'(ui[7:4]);
        d  = int'(ui[3:0]);
        va = m_regs[int'(uio[7:4])];
        vb = m_regs[int'(uio[3:0])];
        res = 0; wr = 0; upd = 0;
        if (r) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_out = 0;
        end else if (e) begin
            case (op)
                8:  begin res = m_regs[d];               upd = 1; end
                9:  begin res = int'(uio);               upd = 1; wr = 1; end
                10: begin res = (va + vb) % 256;         upd = 1; wr = 1; end
                11: begin res = (va - vb + 256) % 256;   upd = 1; wr = 1; end
                12: begin res = va & vb;                 upd = 1; wr = 1; end
                13: begin res = va | vb;                 upd = 1; wr = 1; end
                14: begin res = va ^ vb;                 upd = 1; wr = 1; end
                default: ;
            endcase
            if (wr)  m_regs[d] = res;
            if (upd) m_out = res;
        end
        #1;
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b1, 8'h00, 8'h00);
        apply(1'b1, 1'b1, 8'h00, 8'h00);
        n_checks++;
        if (uo_out !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_uo_out: got %h expected 00", uo_out);
        end
        n_checks++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_pins: got uio_out=%h uio_oe=%h expected 00/00", uio_out, uio_oe);
        end
    endtask

    task automatic test_load_add();
        logic [7:0] ui_v [4]  = '{8'h90, 8'h91, 8'hA2, 8'h82};
        logic [7:0] uio_v [4] = '{8'h48, 8'h81, 8'h01, 8'h00};
        logic [7:0] exp_v [4] = '{8'h48, 8'h81, 8'hC9, 8'hC9};
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, ui_v[i], uio_v[i]);
            n_checks++;
            if (uo_out !== exp_v[i]) begin
                n_fails++;
                $display("FAIL load_add[%0d]: got %h expected %h", i, uo_out, exp_v[i]);
            end
        end
    endtask

    task automatic test_wrap();
        apply(1'b0, 1'b1, 8'h93, 8'hFF);
        apply(1'b0, 1'b1, 8'h94, 8'h01);
        apply(1'b0, 1'b1, 8'hA5, 8'h34);
        n_checks++;
        if (uo_out !== 8'h00) begin
            n_fails++;
            $display("FAIL add_wrap: got %h expected 00", uo_out);
        end
        apply(1'b0, 1'b1, 8'hB6, 8'h43);
        n_checks++;
        if (uo_out !== 8'h02) begin
            n_fails++;
            $display("FAIL sub_wrap: got %h expected 02", uo_out);
        end
    endtask

    task automatic test_logic();
        apply(1'b0, 1'b1, 8'hC0, 8'h01);
        n_checks++;
        if (uo_out !== 8'h00) begin
            n_fails++;
            $display("FAIL and_self_overwrite: got %h expected 00", uo_out);
        end
        apply(1'b0, 1'b1, 8'h80, 8'h00);
        n_checks++;
        if (uo_out !== 8'h00) begin
            n_fails++;
            $display("FAIL read_r0_after_and: got %h expected 00", uo_out);
        end
        apply(1'b0, 1'b1, 8'hE7, 8'h11);
        n_checks++;
        if (uo_out !== 8'h00) begin
            n_fails++;
            $display("FAIL xor_same: got %h expected 00", uo_out);
        end
        apply(1'b0, 1'b1, 8'hD8, 8'h11);
        n_checks++;
        if (uo_out !== 8'h81) begin
            n_fails++;
            $display("FAIL or_same: got %h expected 81", uo_out);
        end
    endtask

    task automatic test_enable_hold();
        apply(1'b0, 1'b1, 8'h90, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 8'h90, 8'hAA);
            n_checks++;
            if (uo_out !== 8'h3C) begin
                n_fails++;
                $display("FAIL ena_hold[%0d]: got %h expected 3c", i, uo_out);
            end
        end
        apply(1'b0, 1'b1, 8'h80, 8'h00);
        n_checks++;
        if (uo_out !== 8'h3C) begin
            n_fails++;
            $display("FAIL ena_hold_read_r0: got %h expected 3c", uo_out);
        end
    endtask

    task automatic test_reset_mid();
        apply(1'b0, 1'b1, 8'h91, 8'h55);
        apply(1'b1, 1'b1, 8'hA2, 8'h01);
        n_checks++;
        if (uo_out !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_mid_uo_out: got %h expected 00", uo_out);
        end
        apply(1'b0, 1'b1, 8'h81, 8'h00);
        n_checks++;
        if (uo_out !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_mid_read_r1: got %h expected 00", uo_out);
        end
        apply(1'b0, 1'b1, 8'h82, 8'h00);
        n_checks++;
        if (uo_out !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_mid_read_r2: got %h expected 00", uo_out);
        end
    endtask

    task automatic test_nop();
        logic [7:0] nops [6] = '{8'h00, 8'h7F, 8'h09, 8'h00, 8'h7F, 8'hF3};
        apply(1'b0, 1'b1, 8'h99, 8'h5A);
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b1, nops[i], 8'($urandom));
            n_checks++;
            if (uo_out !== 8'h5A || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
                n_fails++;
                $display("FAIL nop_hold[%0d]: got uo=%h uio_out=%h uio_oe=%h expected 5a/00/00",
                         i, uo_out, uio_out, uio_oe);
            end
        end
        apply(1'b0, 1'b1, 8'h89, 8'h00);
        n_checks++;
        if (uo_out !== 8'h5A) begin
            n_fails++;
            $display("FAIL nop_read_r9: got %h expected 5a", uo_out);
        end
    endtask

    task automatic test_random();
        logic [7:0] ui, uio;
        logic e;
        for (int i = 0; i < 400; i++) begin
            ui  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) ui[7] = 1'b1;
            uio = 8'($urandom);
            e   = ($urandom_range(0, 9) != 0);
            apply(($urandom_range(0, 99) == 0), e, ui, uio);
            n_checks++;
            if (uo_out !== 8'(m_out) || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
                n_fails++;
                $display("FAIL random[%0d] ui=%h uio=%h ena=%b: got uo=%h uio_out=%h uio_oe=%h expected %h/00/00",
                         i, ui, uio, e, uo_out, uio_out, uio_oe, 8'(m_out));
            end
        end
        for (int r = 0; r < 16; r++) begin
            apply(1'b0, 1'b1, {4'b1000, 4'(r)}, 8'h00);
            n_checks++;
            if (uo_out !== 8'(m_out)) begin
                n_fails++;
                $display("FAIL random_regfile R%0d: got %h expected %h", r, uo_out, 8'(m_out));
            end
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        m_out  = 0;
        foreach (m_regs[i]) m_regs[i] = 0;
        @(negedge clk);
        test_reset();
        test_load_add();
        test_wrap();
        test_logic();
        test_enable_hold();
        test_reset_mid();
        test_nop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
